// File: rtl/alu_response_compactor.sv
// alu_response_compactor: folds ALU result beats into a MISR signature
// and compares it with a golden value to give one pass/fail verdict.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   start         begin a run (honoured in IDLE or DONE)
//   in_valid      result beat present
//   in_ready      beats accepted (RUN only)
//   res_data      ALU result word
//   res_flags     ALU flags {carry, zero}
//   golden        expected signature, sampled in CHECK
//   busy          RUN or CHECK
//   done          DONE
//   pass          latched compare result
//   signature     current MISR state
//   vec_cnt       beats accepted this run
module alu_response_compactor #(
  parameter int               WIDTH     = 16,
  parameter int               VEC_COUNT = 65536,
  parameter logic [WIDTH-1:0] POLY      = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic [1:0]       res_flags,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [16:0]      vec_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [16:0] LAST = 17'(VEC_COUNT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [16:0]      cnt_q;
  logic [16:0]      cnt_d;
  logic             pass_q;
  logic             pass_d;
  logic             accept;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] misr_next;

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign accept   = in_valid & in_ready;

  assign fold = {{(WIDTH-2){1'b0}}, res_flags};

  assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                   ^ (sig_q[WIDTH-1] ? POLY : '0)
                   ^ res_data
                   ^ fold;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = '1;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 17'd1;
          if (cnt_q == LAST) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        pass_d  = (sig_q == golden);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= '1;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign signature = sig_q;
  assign vec_cnt   = cnt_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_alu_response_compactor.sv
// tb_alu_response_compactor: directed checks of the response compactor
// over small runs, handshake gaps, reset, and a full operand sweep.
module tb_alu_response_compactor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] res_data;
  logic [15:0] res_data_f;
  logic [15:0] fmask;
  logic [1:0]  res_flags;
  logic [15:0] golden;
  logic [4:0]  st;
  logic [4:0]  rdy;
  logic [4:0]  bsy;
  logic [4:0]  dn;
  logic [4:0]  ps;
  logic [15:0] sg [5];
  logic [16:0] vc [5];

  int n_cmp;
  int n_bad;

  assign res_data_f = res_data ^ fmask;

  alu_response_compactor #(.VEC_COUNT(1)) u1 (
    .clk(clk), .rst(rst), .start(st[0]),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .res_data(res_data), .res_flags(res_flags),
    .golden(golden), .busy(bsy[0]), .done(dn[0]),
    .pass(ps[0]), .signature(sg[0]), .vec_cnt(vc[0])
  );

  alu_response_compactor #(.VEC_COUNT(2)) u2 (
    .clk(clk), .rst(rst), .start(st[1]),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .res_data(res_data), .res_flags(res_flags),
    .golden(golden), .busy(bsy[1]), .done(dn[1]),
    .pass(ps[1]), .signature(sg[1]), .vec_cnt(vc[1])
  );

  alu_response_compactor #(.VEC_COUNT(4)) u4 (
    .clk(clk), .rst(rst), .start(st[2]),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .res_data(res_data), .res_flags(res_flags),
    .golden(golden), .busy(bsy[2]), .done(dn[2]),
    .pass(ps[2]), .signature(sg[2]), .vec_cnt(vc[2])
  );

  alu_response_compactor u_good (
    .clk(clk), .rst(rst), .start(st[3]),
    .in_valid(in_valid), .in_ready(rdy[3]),
    .res_data(res_data), .res_flags(res_flags),
    .golden(golden), .busy(bsy[3]), .done(dn[3]),
    .pass(ps[3]), .signature(sg[3]), .vec_cnt(vc[3])
  );

  alu_response_compactor u_bad (
    .clk(clk), .rst(rst), .start(st[4]),
    .in_valid(in_valid), .in_ready(rdy[4]),
    .res_data(res_data_f), .res_flags(res_flags),
    .golden(golden), .busy(bsy[4]), .done(dn[4]),
    .pass(ps[4]), .signature(sg[4]), .vec_cnt(vc[4])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s,
                                       input logic [15:0] d,
                                       input logic [1:0]  f);
    logic [15:0] p;
    p = s[15] ? 16'h1021 : 16'h0000;
    return {s[14:0], 1'b0} ^ p ^ d ^ {14'b0, f};
  endfunction

  function automatic void ref_alu(input  logic [7:0]  a,
                                  input  logic [7:0]  b,
                                  output logic [15:0] d,
                                  output logic [1:0]  f);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    d = {a ^ b, s[7:0]};
    f = {s[8], s[7:0] == 8'h00};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic v,
                      input logic [15:0] d,
                      input logic [1:0] f);
    in_valid  = v;
    res_data  = d;
    res_flags = f;
    step();
  endtask

  logic [15:0] e;
  logic [15:0] gold;
  logic [15:0] d;
  logic [1:0]  f;
  logic [6:0]  pat;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_data  = '0;
    res_flags = '0;
    golden    = '0;
    fmask     = '0;
    st        = '0;
    step();
    step();

    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_pass", 32'(ps[0]), 32'd0);
    check("rst_sig", 32'(sg[0]), 32'hFFFF);
    check("rst_cnt", 32'(vc[0]), 32'd0);
    rst = 1'b0;
    step();

    // single-beat run
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    check("t1_ready", 32'(rdy[0]), 32'd1);
    check("t1_busy", 32'(bsy[0]), 32'd1);
    check("t1_sig0", 32'(sg[0]), 32'hFFFF);
    golden = 16'hEFDF;
    beat(1'b1, 16'h0000, 2'b00);
    in_valid = 1'b0;
    check("t1_sig", 32'(sg[0]), 32'hEFDF);
    check("t1_cnt", 32'(vc[0]), 32'd1);
    check("t1_chk_rdy", 32'(rdy[0]), 32'd0);
    check("t1_chk_done", 32'(dn[0]), 32'd0);
    step();
    check("t1_done", 32'(dn[0]), 32'd1);
    check("t1_pass", 32'(ps[0]), 32'd1);
    check("t1_busy_end", 32'(bsy[0]), 32'd0);

    // two-beat run, wrong golden
    st[1] = 1'b1;
    step();
    st[1] = 1'b0;
    beat(1'b1, 16'h0000, 2'b00);
    check("t2_sig1", 32'(sg[1]), 32'hEFDF);
    golden = 16'h0000;
    beat(1'b1, 16'h1234, 2'b01);
    in_valid = 1'b0;
    check("t2_sig2", 32'(sg[1]), 32'hDDAA);
    check("t2_cnt", 32'(vc[1]), 32'd2);
    step();
    check("t2_done", 32'(dn[1]), 32'd1);
    check("t2_pass", 32'(ps[1]), 32'd0);

    // gapped valid on a four-beat run
    st[2] = 1'b1;
    step();
    st[2] = 1'b0;
    e   = 16'hFFFF;
    pat = 7'b1011001;
    for (int k = 0; k < 7; k++) begin
      int exp_cnt [7] = '{1, 1, 1, 2, 3, 3, 4};
      d = 16'hA000 + 16'(k);
      f = 2'(k);
      if (pat[k]) e = misr(e, d, f);
      beat(pat[k], d, f);
      check($sformatf("t3_cnt%0d", k), 32'(vc[2]), 32'(exp_cnt[k]));
      if (k == 6) golden = e;
    end
    in_valid = 1'b0;
    check("t3_sig", 32'(sg[2]), 32'(e));
    check("t3_nodone", 32'(dn[2]), 32'd0);
    step();
    check("t3_done", 32'(dn[2]), 32'd1);
    check("t3_pass", 32'(ps[2]), 32'd1);

    // beats offered in DONE are ignored
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 16'h5A5A, 2'b11);
      check("t5_ready", 32'(rdy[2]), 32'd0);
    end
    in_valid = 1'b0;
    check("t5_sig", 32'(sg[2]), 32'(e));
    check("t5_cnt", 32'(vc[2]), 32'd4);
    check("t5_pass_hold", 32'(ps[2]), 32'd1);
    st[2] = 1'b1;
    step();
    st[2] = 1'b0;
    check("t5_pass_clr", 32'(ps[2]), 32'd0);
    check("t5_done_clr", 32'(dn[2]), 32'd0);
    check("t5_sig_init", 32'(sg[2]), 32'hFFFF);
    check("t5_cnt_init", 32'(vc[2]), 32'd0);

    // start ignored mid-run, then async reset
    e = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      d = 16'h0F00 + 16'(k);
      e = misr(e, d, 2'b10);
      beat(1'b1, d, 2'b10);
    end
    check("t4_cnt2", 32'(vc[2]), 32'd2);
    st[2] = 1'b1;
    e = misr(e, 16'h0F02, 2'b10);
    beat(1'b1, 16'h0F02, 2'b10);
    st[2]    = 1'b0;
    in_valid = 1'b0;
    check("t4_cnt3", 32'(vc[2]), 32'd3);
    check("t4_sig3", 32'(sg[2]), 32'(e));
    check("t4_busy", 32'(bsy[2]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_sig", 32'(sg[2]), 32'hFFFF);
    check("t4_rst_cnt", 32'(vc[2]), 32'd0);
    check("t4_rst_busy", 32'(bsy[2]), 32'd0);
    check("t4_rst_done", 32'(dn[2]), 32'd0);
    step();
    rst = 1'b0;
    beat(1'b1, 16'h1111, 2'b00);
    beat(1'b1, 16'h2222, 2'b00);
    in_valid = 1'b0;
    check("t4_idle_rdy", 32'(rdy[2]), 32'd0);
    check("t4_idle_cnt", 32'(vc[2]), 32'd0);

    // full sweep: good and single-bit-fault instances in parallel
    gold = 16'hFFFF;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ref_alu(8'(a), 8'(b), d, f);
        gold = misr(gold, d, f);
      end
    end
    golden = gold;
    st[4:3] = 2'b11;
    step();
    st[4:3] = 2'b00;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ref_alu(8'(a), 8'(b), d, f);
        fmask = (a == 17 && b == 200) ? 16'h0100 : 16'h0000;
        beat(1'b1, d, f);
      end
    end
    in_valid = 1'b0;
    fmask    = '0;
    check("t6_cnt", 32'(vc[3]), 32'h10000);
    check("t6_sig", 32'(sg[3]), 32'(gold));
    check("t6_cnt_f", 32'(vc[4]), 32'h10000);
    for (int k = 0; k < 4; k++) begin
      if (dn[3]) break;
      step();
    end
    check("t6_done", 32'(dn[3]), 32'd1);
    check("t6_pass", 32'(ps[3]), 32'd1);
    check("t6_done_f", 32'(dn[4]), 32'd1);
    check("t6_pass_f", 32'(ps[4]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
